// File: rtl/hazard_ctrl_unit.sv
// Load-use / control-hazard controller for the 16-bit 5-stage core.
// Ports: clk_i, rst_n, ifid_rs_i/rt_i/uses_rt_i, idex_memread_i, idex_wr_addr_i,
//        ex_redirect_i, clr_cnt_i -> pc_write_o, ifid_write_o, ifid_flush_o,
//        DHZ_o, CHZ_o, busy_o, stall_cnt_o, flush_cnt_o.
module hazard_ctrl_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_AW       = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_wr_addr_i,
    input  logic              ex_redirect_i,
    input  logic              clr_cnt_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              DHZ_o,
    output logic              CHZ_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [RW-1:0] REM_LOAD = RW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic            load_use;
    logic            stall_ev, flush_ev;

    assign load_use = idex_memread_i
                    & (idex_wr_addr_i != '0)
                    & ((idex_wr_addr_i == ifid_rs_i)
                    |  (ifid_uses_rt_i & (idex_wr_addr_i == ifid_rt_i)));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        unique case (state_q)
            IDLE, LU_STALL: begin
                if (ex_redirect_i) begin
                    flush_ev = 1'b1;
                    rem_d    = REM_LOAD;
                    state_d  = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
                end else if (load_use) begin
                    stall_ev = 1'b1;
                    state_d  = LU_STALL;
                end else begin
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                if (ex_redirect_i) begin
                    flush_ev = 1'b1;
                    rem_d    = REM_LOAD;
                end else if (rem_q <= RW'(1)) begin
                    rem_d   = '0;
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Outputs are forced to pass-through while reset is asserted so a
    // redirect or load seen during reset cannot bubble or flush the pipe.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        DHZ_o        = 1'b0;
        CHZ_o        = 1'b0;
        busy_o       = (state_q != IDLE);
        unique case (state_q)
            IDLE, LU_STALL: begin
                if (ex_redirect_i) begin
                    CHZ_o        = 1'b1;
                    ifid_flush_o = 1'b1;
                end else if (load_use) begin
                    DHZ_o        = 1'b1;
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                end
            end
            FLUSH: begin
                CHZ_o        = 1'b1;
                ifid_flush_o = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b0;
            DHZ_o        = 1'b0;
            CHZ_o        = 1'b0;
            busy_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_ev && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
